// File: rtl/fifo_reader_if.sv
// FIFO read-port and payload-stream signals for fifo_reader.
// master is the drain engine, slave is the FIFO plus downstream environment.
interface fifo_reader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_read;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        input  fifo_data, fifo_empty, out_ready,
        output fifo_read, out_data, out_valid, out_last
    );

    modport slave (
        output fifo_data, fifo_empty, out_ready,
        input  fifo_read, out_data, out_valid, out_last
    );
endinterface

// File: rtl/fifo_reader.sv
// Drains length-prefixed packets from a show-ahead FIFO, strips the header and
// forwards the payload on a registered valid/ready stream with a last marker.
module fifo_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_BITS   = 8,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                reset,
    fifo_reader_if.master       bus,
    output logic                busy,
    output logic                err_zero_len,
    output logic [CNT_BITS-1:0] pkt_count
);
    typedef enum logic {StHdr, StPay} state_e;

    localparam logic [LEN_BITS-1:0] LenOne = LEN_BITS'(1);
    localparam logic [CNT_BITS-1:0] CntOne = CNT_BITS'(1);

    state_e                state_q, state_d;
    logic [LEN_BITS-1:0]   remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  err_q, err_d;
    logic [CNT_BITS-1:0]   pkt_count_q, pkt_count_d;
    logic                  pop;
    logic                  accept;
    logic [LEN_BITS-1:0]   len;

    always_comb begin
        // In PAY a pop is allowed only when the output register is free or draining.
        pop = !bus.fifo_empty &&
              (state_q == StHdr || (state_q == StPay && (!out_valid_q || bus.out_ready)));
        accept = out_valid_q && bus.out_ready;
        len    = bus.fifo_data[LEN_BITS-1:0];

        state_d     = state_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;
        pkt_count_d = pkt_count_q;

        if (accept) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (out_last_q) begin
                pkt_count_d = pkt_count_q + CntOne;
            end
        end

        if (pop) begin
            unique case (state_q)
                StHdr: begin
                    if (len != '0) begin
                        remaining_d = len;
                        state_d     = StPay;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                StPay: begin
                    out_data_d  = bus.fifo_data;
                    out_valid_d = 1'b1;
                    out_last_d  = (remaining_q == LenOne);
                    remaining_d = remaining_q - LenOne;
                    if (remaining_q == LenOne) begin
                        state_d = StHdr;
                    end
                end
                default: state_d = StHdr;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StHdr;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign bus.fifo_read = pop;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q == StPay) || out_valid_q;
    assign err_zero_len  = err_q;
    assign pkt_count     = pkt_count_q;
endmodule

// File: doc/fifo_reader.md
# fifo_reader

Consumer-side drain engine for the 32-bit synchronous FIFO. It pops length-prefixed packets from the FIFO's show-ahead read port, strips the header word, and presents the payload on a registered valid/ready stream with a last-word marker. It sits between the FIFO's read/empty/output_data pins and downstream logic that needs packet framing and backpressure instead of raw pops.

## Interface
Parameters:
- DATA_WIDTH, 32, width of FIFO words and output data
- LEN_BITS, 8, width of the header length field, taken from header bits [LEN_BITS-1:0]
- CNT_BITS, 16, width of the completed-packet counter

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- fifo_data  input  DATA_WIDTH  FIFO head word, valid combinationally whenever fifo_empty=0
- fifo_empty  input  1  FIFO empty flag
- fifo_read  output  1  pop request; the FIFO advances on the clk edge where fifo_read=1 and fifo_empty=0
- out_data  output  DATA_WIDTH  payload word
- out_valid  output  1  out_data holds a valid word
- out_last  output  1  final payload word of the packet, qualified by out_valid
- out_ready  input  1  downstream accepts the word when out_valid=1 and out_ready=1
- busy  output  1  high in state PAY or while out_valid=1
- err_zero_len  output  1  one-cycle pulse when a zero-length header is dropped
- pkt_count  output  CNT_BITS  count of completed packets

## Operation
- FSM has two states. HDR waits for a header. PAY forwards payload words. Reset state is HDR.
- Pop rule (combinational): fifo_read = !fifo_empty && (state==HDR || (state==PAY && (!out_valid || out_ready))). fifo_read is never asserted while fifo_empty=1.
- HDR, pop with len = fifo_data[LEN_BITS-1:0]:
  - len≠0: remaining <= len; state <= PAY.
  - len=0: the header is dropped. err_zero_len=1 on the next cycle. State stays HDR. pkt_count is unchanged.
  - Header bits above LEN_BITS are ignored.
- PAY, pop:
  - out_data <= fifo_data; out_valid <= 1; out_last <= (remaining==1); remaining <= remaining-1.
  - If remaining==1, state <= HDR.
- Output register:
  - On out_valid && out_ready with no pop in the same cycle, out_valid <= 0 and out_last <= 0.
  - A pop in the same cycle as an accept reloads the register, giving full throughput.
  - out_data holds its value while out_valid=1 and out_ready=0.
- pkt_count increments by 1 on each cycle where out_valid && out_ready && out_last. It wraps modulo 2^CNT_BITS.
- The header pop for the next packet may occur while the last word of the previous packet is still held in the output register.
- remaining is LEN_BITS wide, so the maximum packet is 2^LEN_BITS-1 payload words.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, err_zero_len=0, pkt_count=0, busy=0, state=HDR, remaining=0. fifo_read follows from the pop rule and is 0 only while fifo_empty=1.
- Latency:
  - Header at the FIFO head at edge N: popped at N. First payload popped at N+1. out_valid=1 after edge N+1.
  - This gives 2 cycles from header-visible to first output, with one bubble per header.
- Throughput: 1 payload word per cycle when out_ready=1 and the FIFO is non-empty.
- Backpressure: with out_valid=1 and out_ready=0, fifo_read=0 in PAY, and no word is lost or duplicated.
- FIFO empty mid-packet: state stays PAY and remaining holds. out_valid drops after the current word is accepted, and forwarding resumes on the next non-empty cycle.
- Reset mid-packet:
  - All state clears immediately and asynchronously; out_valid=0 with no clock needed.
  - FIFO contents are untouched. The FIFO must be reset in the same reset window, otherwise residual payload is parsed as headers.
- err_zero_len is high for exactly one cycle per dropped header. Back-to-back zero-length headers give consecutive pulses.

## Test plan
- Single packet, out_ready=1: FIFO holds {0x3, 0xA, 0xB, 0xC}. Outputs are 0xA, 0xB, 0xC on 3 consecutive cycles starting 2 cycles after the first pop. out_last=1 only on 0xC. pkt_count goes 0→1. The FIFO is empty afterwards.
- Backpressure: same packet with out_ready low for 4 cycles while 0xA is valid. 0xA holds steady, fifo_read=0 during the stall, and all three words arrive in order.
- Zero-length and back-to-back: FIFO holds {0x0, 0x1, 0x55, 0x2, 0x66, 0x77}.
  - One err_zero_len pulse.
  - Outputs are 0x55(last), 0x66, 0x77(last).
  - pkt_count reaches 2.
  - There is no gap between 0x55 accept and the next header pop.
- Underflow mid-packet: header 0x4 with only 2 payload words, then 5 empty cycles, then 2 more words. Output is 4 words, with out_last only on the 4th. busy stays high during the gap.
- Async reset mid-packet: assert reset after the 2nd of 3 payload words without a clock edge. out_valid, busy and pkt_count read 0 immediately. After release with a fresh FIFO holding {0x1, 0x99}, 0x99 is output with out_last=1.
- Max length and counter wrap:
  - Header 0xFF (LEN_BITS=8) yields 255 words with out_last only on the last.
  - Preload CNT_BITS=4 and run 16 packets; pkt_count wraps to 0.
